// File: rtl/counter_loader_pkg.sv
// rtl/counter_loader_pkg.sv - shared types and constants for the counter loader
package counter_loader_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/counter_loader_sync_fifo.sv
// rtl/counter_loader_sync_fifo.sv - request buffer: single-clock FIFO, DEPTH a power of 2 (>= 2)
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap for free because DEPTH is a power of 2
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/counter_loader.sv
// rtl/counter_loader.sv - buffered counter loader with optional readback check (COUNTER_LOADER_CHECK_EN)
module counter_loader
  import counter_loader_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [DATA_W-1:0] wdata,
  output logic              wr,
  input  logic [DATA_W-1:0] data_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              ready_en_q, ready_en_d;
  logic              load;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
`ifdef COUNTER_LOADER_CHECK_EN
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
`endif

  // ready_en_q keeps req_ready low through reset and sets it on the first edge after release
  assign req_ready = ready_en_q && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign wr        = wr_q;
  assign wdata     = wr_q ? hold_q : '0;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (req_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    ready_en_d = 1'b1;
    fifo_pop   = 1'b0;
    load       = 1'b0;
`ifdef COUNTER_LOADER_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        load = !fifo_empty;
      end
`ifdef COUNTER_LOADER_CHECK_EN
      ST_WRITE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        done_d  = 1'b1;
        err_d   = (data_cnt != hold_q);
        state_d = ST_IDLE;
        load    = !fifo_empty;
      end
`else
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        load    = !fifo_empty;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Every entry into WRITE pops the head into hold and raises the strobe for one cycle
    if (load) begin
      fifo_pop = 1'b1;
      hold_d   = fifo_dout;
      wr_d     = 1'b1;
      state_d  = ST_WRITE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      ready_en_q <= ready_en_d;
    end
  end

`ifdef COUNTER_LOADER_CHECK_EN
  always_comb begin
    err_count_d = err_count_q;
    if (err_q && (err_count_q != ERR_CNT_MAX)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;
`else
  logic unused_data_cnt;
  assign unused_data_cnt = ^data_cnt;
  assign err             = 1'b0;
  assign err_count       = '0;
`endif

endmodule

// File: tb/tb_counter_loader.sv
// tb/tb_counter_loader.sv - directed self-checking bench for counter_loader
module tb_counter_loader;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] req_data  = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] wdata;
  logic       wr;
  logic [7:0] data_cnt;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_count;

  logic       ignore_wr = 1'b0;
  logic [7:0] cnt_model;
  int         n_cmp = 0;
  int         n_bad = 0;

`ifdef COUNTER_LOADER_CHECK_EN
  localparam int WR_GAP = 2;
`else
  localparam int WR_GAP = 1;
`endif

  counter_loader #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .wdata     (wdata),
    .wr        (wr),
    .data_cnt  (data_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Counter being loaded; ignore_wr models a broken counter that never takes the write
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt_model <= 8'h00;
    else if (wr && !ignore_wr) cnt_model <= wdata;
  end
  assign data_cnt = cnt_model;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #4;
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({wr, wdata, req_ready, busy, done, err, err_count} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_hold outputs=%h expected=0", {wr, wdata, req_ready, busy, done, err, err_count});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_before_edge req_ready=%b expected=0", req_ready);
    end
    cycle();
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_edge req_ready=%b busy=%b expected=1,0", req_ready, busy);
    end
  endtask

  task automatic test_single();
    logic       e_wr   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] e_wd   [5] = '{8'h00, 8'h55, 8'h00, 8'h00, 8'h00};
`ifdef COUNTER_LOADER_CHECK_EN
    logic       e_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       e_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    logic       e_done [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       e_busy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    req_data  = 8'h55;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({wr, wdata, done, err, busy} !== {e_wr[i], e_wd[i], e_done[i], 1'b0, e_busy[i]}) begin
        n_bad++;
        $display("FAIL single_c%0d wr,wdata,done,err,busy=%b,%h,%b,%b,%b expected=%b,%h,%b,0,%b",
                 i + 1, wr, wdata, done, err, busy, e_wr[i], e_wd[i], e_done[i], e_busy[i]);
      end
      if (i < 4) cycle();
    end
    n_cmp++;
    if (err_count !== 8'd0 || cnt_model !== 8'h55) begin
      n_bad++;
      $display("FAIL single_after err_count=%h counter=%h expected=00,55", err_count, cnt_model);
    end
  endtask

  task automatic test_two_requests();
`ifdef COUNTER_LOADER_CHECK_EN
    logic [7:0] e_wd [5] = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00};
    logic       e_wr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    logic [7:0] e_wd [5] = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h00};
    logic       e_wr [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    req_data  = 8'h11;
    req_valid = 1'b1;
    cycle();
    req_data = 8'h22;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req_valid = 1'b0;
      n_cmp++;
      if ({wr, wdata, err} !== {e_wr[i], e_wd[i], 1'b0}) begin
        n_bad++;
        $display("FAIL two_req_c%0d wr,wdata,err=%b,%h,%b expected=%b,%h,0",
                 i + 1, wr, wdata, err, e_wr[i], e_wd[i]);
      end
      cycle();
    end
    repeat (4) cycle();
  endtask

  task automatic test_back_to_back(input int n);
    logic [7:0] seen [$];
    int sent = 0, dones = 0, errs = 0, gap_bad = 0, last_wr = -1;
    logic acc;
    req_data  = 8'h01;
    req_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      acc = req_valid && req_ready;
      cycle();
      if (acc) sent++;
      if (wr) begin
        seen.push_back(wdata);
        if (last_wr >= 0 && (c - last_wr) != WR_GAP) gap_bad++;
        last_wr = c;
      end
      if (done) dones++;
      if (err) errs++;
`ifdef COUNTER_LOADER_CHECK_EN
      if (n == 8 && (c == 6 || c == 7)) begin
        n_cmp++;
        if (req_ready !== (c == 6)) begin
          n_bad++;
          $display("FAIL b2b_ready_c%0d req_ready=%b expected=%b", c, req_ready, c == 6);
        end
      end
`endif
      if (sent == n) req_valid = 1'b0;
      else req_data = 8'(sent + 1);
    end
    n_cmp++;
    if (sent != n || seen.size() != n || dones != n || errs != 0 || gap_bad != 0) begin
      n_bad++;
      $display("FAIL b2b_%0d accepted=%0d writes=%0d done=%0d err=%0d bad_gaps=%0d expected=%0d,%0d,%0d,0,0",
               n, sent, seen.size(), dones, errs, gap_bad, n, n, n);
    end
    for (int i = 0; i < seen.size() && i < n; i++) begin
      n_cmp++;
      if (seen[i] !== 8'(i + 1)) begin
        n_bad++;
        $display("FAIL b2b_%0d_order[%0d] wdata=%h expected=%h", n, i, seen[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_mismatch();
    int timeouts = 0, err_miss = 0;
    logic got;
    pulse_reset();
    ignore_wr = 1'b1;
    req_data  = 8'hA5;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    repeat (3) cycle();
`ifdef COUNTER_LOADER_CHECK_EN
    n_cmp++;
    if ({done, err} !== 2'b11) begin
      n_bad++;
      $display("FAIL mismatch_pulse done,err=%b%b expected=11", done, err);
    end
    cycle();
    n_cmp++;
    if (err_count !== 8'd1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL mismatch_count err_count=%h err=%b expected=01,0", err_count, err);
    end
    for (int k = 2; k <= 300; k++) begin
      req_valid = 1'b1;
      cycle();
      req_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        cycle();
        if (done) begin
          got = 1'b1;
          if (!err) err_miss++;
        end
      end
      if (!got) timeouts++;
      cycle();
      if (k == 254 || k == 255 || k == 300) begin
        n_cmp++;
        if (err_count !== ((k > 255) ? 8'd255 : 8'(k))) begin
          n_bad++;
          $display("FAIL mismatch_sat_%0d err_count=%0d expected=%0d", k, err_count, (k > 255) ? 255 : k);
        end
      end
    end
    n_cmp++;
    if (timeouts != 0 || err_miss != 0) begin
      n_bad++;
      $display("FAIL mismatch_loop timeouts=%0d missing_err=%0d expected=0,0", timeouts, err_miss);
    end
`else
    n_cmp++;
    if ({done, err, err_count} !== 10'd0) begin
      n_bad++;
      $display("FAIL nocheck_c4 done,err,err_count=%b,%b,%h expected=0,0,00", done, err, err_count);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (err !== 1'b0 || err_count !== 8'd0) err_miss++;
    end
    n_cmp++;
    if (err_miss != 0) begin
      n_bad++;
      $display("FAIL nocheck_err err_seen_cycles=%0d expected=0", err_miss);
    end
`endif
    ignore_wr = 1'b0;
  endtask

  task automatic test_reset_pulse();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr, wdata, req_ready, busy, done, err, err_count} !== 21'd0) begin
      n_bad++;
      $display("FAIL pulse_hold outputs=%h expected=0", {wr, wdata, req_ready, busy, done, err, err_count});
    end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_before_edge req_ready=%b expected=0", req_ready);
    end
    cycle();
    n_cmp++;
    if (req_ready !== 1'b1 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL pulse_after_edge req_ready=%b err_count=%h expected=1,00", req_ready, err_count);
    end
  endtask

  task automatic test_reset_mid_write();
    int wrs = 0, dones = 0;
    req_data  = 8'h10;
    req_valid = 1'b1;
    cycle();
    req_data = 8'h20;
    cycle();
    req_valid = 1'b0;
    n_cmp++;
    if ({wr, wdata} !== {1'b1, 8'h10}) begin
      n_bad++;
      $display("FAIL abort_write wr,wdata=%b,%h expected=1,10", wr, wdata);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr, wdata, busy, done, req_ready} !== 12'd0) begin
      n_bad++;
      $display("FAIL abort_forced wr,wdata,busy,done,ready=%b,%h,%b,%b,%b expected=0,00,0,0,0",
               wr, wdata, busy, done, req_ready);
    end
    #3;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (wr) wrs++;
      if (done) dones++;
    end
    n_cmp++;
    if (wrs != 0 || dones != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_after wr_pulses=%0d done_pulses=%0d busy=%b expected=0,0,0", wrs, dones, busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    repeat (3) cycle();
    test_two_requests();
    test_back_to_back(4);
    repeat (3) cycle();
    test_back_to_back(8);
    repeat (3) cycle();
    test_mismatch();
    repeat (3) cycle();
    test_reset_pulse();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_loader.md
COUNTER_LOADER -- requirements
Module: counter_loader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of request data, wdata and data_cnt.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the request-buffer depth; power of 2 and at least 2.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port req_data, input, DATA_W: value to load into the counter.
REQ-006 Port req_valid, input, 1: req_data is valid this cycle.
REQ-007 Port req_ready, output, 1: buffer can accept a request.
REQ-008 Port wdata, output, DATA_W: load value driven to the counter write port.
REQ-009 Port wr, output, 1: counter write strobe, one cycle per load.
REQ-010 Port data_cnt, input, DATA_W: counter readback value.
REQ-011 Port busy, output, 1: high when the FSM is not in IDLE or the buffer is non-empty.
REQ-012 Port done, output, 1: one-cycle pulse per completed load.
REQ-013 Port err, output, 1: one-cycle pulse, coincident with done, on readback mismatch.
REQ-014 Port err_count, output, 8: saturating mismatch count.

Function
REQ-015 A request SHALL be accepted on a rising edge when req_valid=1 and req_ready=1, and pushed into the FIFO.
REQ-016 req_ready SHALL equal !full, registered. A pop in the same cycle SHALL NOT raise req_ready in that cycle.
REQ-017 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 FSM states SHALL be IDLE, WRITE and CHECK.
REQ-019 IDLE->WRITE when the FIFO is non-empty: pop the head into a hold register, and drive wr=1 and wdata=head for exactly one cycle.
REQ-020 WRITE->CHECK unconditionally. The counter samples wr at the edge that ends WRITE.
REQ-021 In CHECK, the block SHALL compare data_cnt with the hold register.
REQ-022 The cycle after CHECK SHALL pulse done=1. err SHALL also pulse if the CHECK compare mismatched.
REQ-023 CHECK->WRITE if the FIFO is non-empty, otherwise CHECK->IDLE.
REQ-024 Minimum spacing between wr pulses SHALL be 2 cycles.
REQ-025 When wr=0, wdata SHALL be 0.
REQ-026 Latency: a request accepted at edge T into an empty, idle block SHALL produce wr=1 in the cycle starting at edge T+1.
REQ-027 err_count SHALL increment on each err and hold at 255.

Reset
REQ-028 While reset=0, the following SHALL be forced immediately, independent of clk:
- wr=0, wdata=0, req_ready=0, busy=0, done=0, err=0, err_count=0;
- FSM in IDLE;
- FIFO flushed.
REQ-029 The first rising edge after reset deassertion SHALL set req_ready=1.
REQ-030 Reset during WRITE or CHECK SHALL abort the load with no done or err pulse. All buffered requests SHALL be discarded.

Configuration
REQ-031 Macro COUNTER_LOADER_CHECK_EN defined: the CHECK state and readback compare are present, as specified above.
REQ-032 Macro COUNTER_LOADER_CHECK_EN undefined: the block SHALL behave as follows.
- The CHECK state and compare logic SHALL be absent.
- WRITE SHALL go directly to WRITE (FIFO non-empty) or IDLE.
- done SHALL pulse in the cycle after each WRITE.
- err and err_count SHALL be constant 0.
- data_cnt SHALL be ignored.
- wr pulses MAY be back-to-back.

Structure
REQ-033 Package counter_loader_pkg SHALL hold:
- the FSM state enum type;
- DATA_W_DEF=8 and FIFO_DEPTH_DEF=4;
- the err_count saturation constant 8'hFF.
REQ-034 The request buffer SHALL be a sub-module sync_fifo (parameters DATA_W, DEPTH; ports push, pop, din, dout, full, empty) on the same clk and reset.

Verification
REQ-035 Reset pulse low for 4 time units mid-cycle -> outputs zero during the pulse; req_ready=1 after the next rising edge.
REQ-036 Single request 8'h55 with a counter model that loads on wr -> one wr pulse with wdata=8'h55; done one cycle after CHECK; err=0; err_count=0.
REQ-037 Four back-to-back requests 8'h01..8'h04 at FIFO_DEPTH=4 -> req_ready drops when full; wr pulses every 2 cycles in order 01,02,03,04; four done pulses.
REQ-038 Counter model that ignores wr (data_cnt stays 8'h00), request 8'hA5 -> err pulses with done; err_count=1. After 300 such loads, err_count=255.
REQ-039 Reset asserted during the WRITE of 8'h10 with 8'h20 buffered -> wr drops immediately; no done; 8'h20 never written after release.
REQ-040 Build without COUNTER_LOADER_CHECK_EN, requests 8'h11,8'h22 -> consecutive wr pulses; err stays 0.
